// File: rtl/module_mux_secuenciador.sv
// Scan sequencer that drives the select of an upstream 4:1 mux.
//
// For each channel it holds `sel` for DWELL cycles, so the mux output has time
// to settle. It then registers `mux_out` together with the channel index and
// raises a one-cycle `valido` pulse.
//
// Operating modes:
//   - `en` held high: continuous scanning.
//   - one-cycle `start` pulse: a single pass over the four channels.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   en           continuous scan enable (level)
//   start        single-scan request (one-cycle pulse)
//   mux_out      current output of the 4:1 mux
//   sel          channel select to the mux (00=a, 01=b, 10=c, 11=d)
//   dato         last captured sample
//   canal        channel index of `dato`
//   valido       one-cycle pulse: `dato`/`canal` updated this cycle
//   fin_barrido  one-cycle pulse together with the channel-3 `valido`
//   ocupado      high while a scan is in progress
module module_mux_secuenciador #(
    parameter int unsigned ANCHO = 4,
    parameter int unsigned DWELL = 4   // legal range 2..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [ANCHO-1:0] mux_out,
    output logic [1:0]       sel,
    output logic [ANCHO-1:0] dato,
    output logic [1:0]       canal,
    output logic             valido,
    output logic             fin_barrido,
    output logic             ocupado
);

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    typedef enum logic [0:0] {
        REPOSO,
        BARRIDO
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic [1:0]       canal_q, canal_d;
    logic             valido_q, valido_d;
    logic             fin_q, fin_d;
    logic             ocupado_q, ocupado_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            sel_q     <= '0;
            dato_q    <= '0;
            canal_q   <= '0;
            valido_q  <= 1'b0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            dato_q    <= dato_d;
            canal_q   <= canal_d;
            valido_q  <= valido_d;
            fin_q     <= fin_d;
            ocupado_q <= ocupado_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        dato_d    = dato_q;
        canal_d   = canal_q;
        valido_d  = 1'b0;
        fin_d     = 1'b0;
        ocupado_d = ocupado_q;

        unique case (estado_q)
            REPOSO: begin
                sel_d     = '0;
                cnt_d     = '0;
                ocupado_d = 1'b0;
                if (en || start) begin
                    estado_d  = BARRIDO;
                    ocupado_d = 1'b1;
                end
            end

            BARRIDO: begin
                // `start` is ignored here on purpose: no queuing or restart.
                ocupado_d = 1'b1;
                if (cnt_q == DWELL_M1) begin
                    dato_d   = mux_out;
                    canal_d  = sel_q;
                    valido_d = 1'b1;
                    cnt_d    = '0;
                    sel_d    = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        fin_d = 1'b1;
                        // `en` sampled at the last capture decides continue vs. stop.
                        if (!en) begin
                            estado_d  = REPOSO;
                            ocupado_d = 1'b0;
                            sel_d     = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    assign sel         = sel_q;
    assign dato        = dato_q;
    assign canal       = canal_q;
    assign valido      = valido_q;
    assign fin_barrido = fin_q;
    assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_module_mux_secuenciador.sv
module tb_module_mux_secuenciador;

    localparam int ANCHO = 4;
    localparam int DWELL = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             start;
    logic [ANCHO-1:0] mux_out;
    logic [1:0]       sel;
    logic [ANCHO-1:0] dato;
    logic [1:0]       canal;
    logic             valido;
    logic             fin_barrido;
    logic             ocupado;

    // bench model of the upstream 4:1 mux
    logic [ANCHO-1:0] in_a, in_b, in_c, in_d;

    always_comb begin
        case (sel)
            2'd0:    mux_out = in_a;
            2'd1:    mux_out = in_b;
            2'd2:    mux_out = in_c;
            default: mux_out = in_d;
        endcase
    end

    module_mux_secuenciador #(
        .ANCHO(ANCHO),
        .DWELL(DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .start      (start),
        .mux_out    (mux_out),
        .sel        (sel),
        .dato       (dato),
        .canal      (canal),
        .valido     (valido),
        .fin_barrido(fin_barrido),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 ns after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             st;
        logic             val;
        logic [1:0]       can;
        logic [ANCHO-1:0] dat;
        logic             fin;
        logic             ocu;
        logic [1:0]       sl;
    } vec_t;

    vec_t tbl[18];

    int n_val;
    int n_late;
    int waited;

    function automatic logic [ANCHO-1:0] chan_val(input int ch, input logic [ANCHO-1:0] dval);
        case (ch)
            0:       return 4'd3;
            1:       return 4'd5;
            2:       return 4'd9;
            default: return dval;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single scan from a freshly reset state, row i is the state after edge k+i.
        for (int i = 0; i < 18; i++) begin
            tbl[i].st  = (i == 0);
            tbl[i].val = (i % 4 == 0) && (i >= 4) && (i <= 16);
            tbl[i].fin = (i == 16);
            tbl[i].ocu = (i < 16);
            tbl[i].sl  = (i < 16) ? 2'(i / 4) : 2'd0;
            tbl[i].can = (i >= 4) ? 2'(i / 4 - 1) : 2'd0;
            tbl[i].dat = (i >= 4) ? chan_val(i / 4 - 1, 4'd12) : 4'd0;
        end
        tbl[17].can = 2'd3;
        tbl[17].dat = 4'd12;

        in_a  = 4'd3;
        in_b  = 4'd5;
        in_c  = 4'd9;
        in_d  = 4'd12;
        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;

        // reset held three edges with en high
        repeat (3) tick();
        check("rst_sel", sel, 0);
        check("rst_dato", dato, 0);
        check("rst_canal", canal, 0);
        check("rst_valido", valido, 0);
        check("rst_fin", fin_barrido, 0);
        check("rst_ocupado", ocupado, 0);

        rst_n = 1'b1;
        tick();
        check("release_ocupado", ocupado, 1);
        check("release_sel", sel, 0);
        en = 1'b0;
        waited = 0;
        while (ocupado && waited < 30) begin
            tick();
            waited++;
        end
        check("release_drain_ocupado", ocupado, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // single scan, table driven
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].st;
            tick();
            check($sformatf("single_valido[%0d]", i), valido, tbl[i].val);
            check($sformatf("single_canal[%0d]", i), canal, tbl[i].can);
            check($sformatf("single_dato[%0d]", i), dato, tbl[i].dat);
            check($sformatf("single_fin[%0d]", i), fin_barrido, tbl[i].fin);
            check($sformatf("single_ocupado[%0d]", i), ocupado, tbl[i].ocu);
            check($sformatf("single_sel[%0d]", i), sel, tbl[i].sl);
        end
        start = 1'b0;

        // start while busy must be ignored
        start = 1'b1;
        tick();
        n_val = 0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 6);
            tick();
            if (valido) n_val++;
        end
        start = 1'b0;
        check("busy_start_valido_count", n_val, 4);
        check("busy_start_ocupado", ocupado, 0);

        // continuous scanning, d changes during channel 3 of the second scan
        en = 1'b1;
        tick();
        check("cont_ocupado", ocupado, 1);
        for (int j = 1; j <= 40; j++) begin
            if (j == 30) in_d = 4'd7;
            tick();
            check($sformatf("cont_valido[%0d]", j), valido, (j % 4 == 0));
            if (j % 4 == 0) begin
                check($sformatf("cont_canal[%0d]", j), canal, (j / 4 - 1) % 4);
                check($sformatf("cont_dato[%0d]", j), dato,
                      chan_val((j / 4 - 1) % 4, (j >= 30) ? 4'd7 : 4'd12));
                check($sformatf("cont_fin[%0d]", j), fin_barrido, ((j / 4 - 1) % 4) == 3);
                check($sformatf("cont_ocupado[%0d]", j), ocupado, 1);
            end
        end
        en   = 1'b0;
        in_d = 4'd12;
        waited = 0;
        while (ocupado && waited < 20) begin
            tick();
            waited++;
        end
        check("cont_stop_ocupado", ocupado, 0);
        check("cont_stop_sel", sel, 0);

        // en falls during channel 1: channels 2 and 3 still captured, then idle
        en = 1'b1;
        tick();
        n_val  = 0;
        n_late = 0;
        for (int j = 1; j <= 24; j++) begin
            if (j == 6) en = 1'b0;
            tick();
            if (valido) begin
                if (j > 16) n_late++;
                else n_val++;
            end
            if (j == 12) begin
                check("enfall_canal2", canal, 2);
                check("enfall_dato2", dato, 9);
            end
            if (j == 16) begin
                check("enfall_canal3", canal, 3);
                check("enfall_dato3", dato, 12);
                check("enfall_fin", fin_barrido, 1);
                check("enfall_ocupado_end", ocupado, 0);
            end
        end
        check("enfall_valido_count", n_val, 4);
        check("enfall_late_valido", n_late, 0);

        // reset landing on a capture edge
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("midrst_pre_ocupado", ocupado, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_valido", valido, 0);
        check("midrst_dato", dato, 0);
        check("midrst_sel", sel, 0);
        check("midrst_ocupado", ocupado, 0);
        check("midrst_canal", canal, 0);
        rst_n = 1'b1;
        n_val = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (valido || ocupado) n_val++;
        end
        check("midrst_stays_idle", n_val, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_mux_secuenciador.md
Name: module_mux_secuenciador

Overview:
- Sequencer that sits directly upstream of the 4:1 mux (module_mux_4_1): drives its `sel`, waits a settle/dwell time per channel, then captures the mux `out` into a registered sample tagged with its channel.
- Supports continuous scanning (`en` held high) and single one-pass scans (`start` pulse).
- Downstream logic consumes `dato`/`canal` on the `valido` pulse.

Parameters:
- ANCHO, 4, data width; must match the mux ANCHO.
- DWELL, 4, cycles `sel` is held per channel before capture; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  continuous scan enable, level.
- start  input  1  single-scan request, one-cycle pulse.
- mux_out  input  ANCHO  `out` of module_mux_4_1.
- sel  output  2  channel select to the mux (00=a, 01=b, 10=c, 11=d).
- dato  output  ANCHO  last captured sample.
- canal  output  2  channel index of `dato`.
- valido  output  1  one-cycle pulse: `dato`/`canal` updated this cycle.
- fin_barrido  output  1  one-cycle pulse, coincident with the `valido` for channel 3.
- ocupado  output  1  high while a scan is in progress.

Behaviour:
- Design style:
  - All outputs are registered.
  - Single clock domain.
  - Reset is synchronous and active-low: `rst_n` is sampled only on the rising edge of `clk`.
- Reset values:
  - sel=0, dato=0, canal=0, valido=0, fin_barrido=0, ocupado=0.
  - FSM in REPOSO; dwell counter `cnt`=0.
- FSM states: REPOSO, BARRIDO.
- REPOSO:
  - sel=0, cnt=0, ocupado=0.
  - If `en` or `start` is sampled high at edge k, enter BARRIDO at k.
  - From edge k: ocupado=1, sel=0, cnt=0.
- BARRIDO, each edge:
  - If cnt < DWELL-1: cnt increments; sel is held.
  - If cnt == DWELL-1 (capture edge):
    - dato <= mux_out, canal <= sel, valido <= 1, cnt <= 0, sel <= sel+1 (wraps 3->0).
    - If sel == 3: fin_barrido <= 1.
  - valido and fin_barrido last exactly one cycle; they are cleared on the next edge.
- End of scan, decided at the channel-3 capture edge:
  - en=1: stay in BARRIDO, sel wraps to 0, scanning continues with no gap cycle.
  - en=0: go to REPOSO; ocupado=0 and sel=0 from that edge.
- Latency and throughput:
  - First capture at edge k+DWELL; valido visible in cycle k+DWELL..k+DWELL+1.
  - One full scan = 4*DWELL cycles.
  - Captures are spaced exactly DWELL cycles apart.
- Settle rule: mux_out is sampled only after `sel` has been stable for DWELL-1 full cycles, so the mux combinational path has at least one cycle to settle.
- Boundary conditions:
  - `start` while ocupado=1 is ignored; no queuing and no restart.
  - `start` and `en` high together in REPOSO: single entry; behaviour is governed by `en` at end of scan.
  - `en` falling mid-scan: the current scan completes all 4 channels, then the block goes to REPOSO.
  - `en` rising mid single-scan: scanning becomes continuous.
  - `rst_n`=0 at any edge, including mid-dwell or on a capture edge: all reset values take effect at that edge and no capture occurs.
  - After reset release, the block waits in REPOSO for `en`/`start`.
  - `mux_out` changing during dwell: only the value present at the capture edge is registered.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1 -> all outputs 0, ocupado=0; release -> ocupado=1 on the first edge with en sampled.
- Single scan, DWELL=4, bench mux with a=3, b=5, c=9, d=12, en=0, `start` pulse at edge k:
  - Four valido pulses at k+4, k+8, k+12, k+16 with (canal, dato) = (0,3), (1,5), (2,9), (3,12).
  - fin_barrido coincides with the last pulse.
  - ocupado=0 and sel=0 after edge k+16.
- Continuous: en=1 for 40 cycles, d changed to 7 during channel 3 of the second scan:
  - Uninterrupted valido every 4 cycles; canal sequence 0,1,2,3,0,...
  - Second-scan channel-3 dato=7.
  - No gap cycle between scans.
- en falls mid-scan during channel 1 -> channels 2 and 3 are still captured, then REPOSO; no further valido.
- start pulsed while ocupado=1 -> ignored; exactly 4 valido pulses total for the single scan.
- Reset mid-op: rst_n=0 on a capture edge (cnt=DWELL-1) -> no valido, dato stays 0, sel=0, ocupado=0 at that edge.
